ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte from the FPGA to the attached keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It is the reverse direction of the existing keyboard receive path and shares the same PS/2 clock and data pins. It drives the pins through open-drain enables only, and the device generates all bit clocks.

Parameters:
INHIBIT_CYCLES, 12000, system clocks the PS/2 clock is held low before the request (>=100 us at 100 MHz)
TIMEOUT_CYCLES, 2000000, maximum system clocks between device clock falling edges before the transfer is abandoned (20 ms)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
tx_data  input  8  command byte to send
tx_valid  input  1  request; byte is accepted when tx_valid && tx_ready
tx_ready  output  1  high only in IDLE
busy  output  1  high in any state other than IDLE
ps2_clk_i  input  1  raw PS/2 clock pin level
ps2_data_i  input  1  raw PS/2 data pin level
ps2_clk_oe  output  1  1 = pull the PS/2 clock pin low; 0 = release it
ps2_data_oe  output  1  1 = pull the PS/2 data pin low; 0 = release it
done  output  1  one-cycle pulse: frame sent and device ACK received
ack_err  output  1  one-cycle pulse: frame sent but no ACK from the device
timeout  output  1  one-cycle pulse: transfer abandoned by the watchdog

Behaviour:
- Input sync: ps2_clk_i and ps2_data_i each pass through a 2-flop synchronizer; all synchronizer flops reset to 1.
- Falling-edge detect: fall = (previous synced clock == 1) && (synced clock == 0). fall asserts 3 clk cycles after the pin drops.
- Reset values: tx_ready=1, busy=0, ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_err=0, timeout=0, state=IDLE.
- Reset mid-frame: both lines are released immediately (asynchronously), the frame is dropped, and no result pulse is generated.
- Frame shift register: 10 bits = tx_data[7:0] LSB first, then odd parity (~^tx_data), then stop bit 1. It is latched on acceptance.
- IDLE: on tx_valid && tx_ready, latch the frame and go to INHIBIT next cycle.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. ps2_data_oe=1 on the final cycle only (start bit 0). Then go to REQ.
- REQ: ps2_clk_oe=0, ps2_data_oe=1. Clear the bit counter and the watchdog. Wait for fall.
- SHIFT: on falls 1..10 the host presents frame bit n-1 on data; ps2_data_oe = ~bit, so the stop bit releases the line. Data changes only on the cycle fall is seen.
- ACK check: on fall 11, sample synced data. 0 means ACK ok, 1 means ACK missing. Go to WAIT_IDLE.
- WAIT_IDLE: both oe=0. Wait until synced clock and data are both 1. Then pulse done (ACK ok) or ack_err (ACK missing) for one cycle and return to IDLE.
- Watchdog: a counter runs in REQ, SHIFT, ACK and WAIT_IDLE and resets on every fall. When it reaches TIMEOUT_CYCLES:
  - both oe=0, timeout pulses for one cycle, state returns to IDLE;
  - done and ack_err are not pulsed.
- Simultaneous events: if a fall and the timeout occur in the same cycle, the fall wins and the watchdog is cleared.
- tx_valid while busy is ignored; there is no queueing.
- Result pulses are mutually exclusive, and each accepted request produces exactly one of done, ack_err or timeout.
- The receive path (KB_input) stays connected. The system must ignore any bytes it decodes while busy=1.

Test Plan:
(All scenarios use INHIBIT_CYCLES=100, TIMEOUT_CYCLES=5000, and a device model clocking at 12 kHz-equivalent that samples data on rising edges.)
- Send 0xED, device ACKs:
  - ps2_clk_oe high for exactly 100 cycles, data_oe high on the last of them;
  - device samples 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done pulses exactly once; tx_ready returns to 1.
- Send 0xF4, device ACKs: device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1; done pulses.
- Send 0x00, device does not pull data low on the 11th clock: parity bit is 1; ack_err pulses once; done stays 0.
- Device never clocks after the request: after REQ plus 5000 cycles, timeout pulses; both oe are 0; tx_ready=1.
- Assert rst_n=0 during bit 4 of 0x55: ps2_clk_oe and ps2_data_oe drop to 0 in the same cycle, with no result pulses. A following send of 0xFF completes with parity 1 and done.
- tx_valid held high while busy with a different tx_data: the frame in flight is unchanged, and the second byte is accepted only after returning to IDLE.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request-to-send,
// then shifts out one byte on device-generated clocks and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE} state_t;
  state_t state;

  logic [1:0] clk_sync, data_sync;
  logic       clk_prev, clk_s, data_s, fall;
  logic [9:0] frame;
  logic [3:0] nfall;
  logic [IW-1:0] inh_cnt;
  logic [WW-1:0] wd_cnt;
  logic       ack_ok, watching, wd_expire;

  assign clk_s     = clk_sync[1];
  assign data_s    = data_sync[1];
  assign fall      = clk_prev & ~clk_s;
  assign watching  = (state == REQ) || (state == SHIFT) || (state == WAIT_IDLE);
  // A fall in the same cycle as expiry clears the watchdog instead of aborting.
  assign wd_expire = watching && !fall && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
      frame       <= '0;
      nfall       <= '0;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      ack_ok      <= 1'b0;
    end else begin
      done    <= 1'b0;
      ack_err <= 1'b0;
      timeout <= 1'b0;
      if (watching) wd_cnt <= fall ? '0 : wd_cnt + 1'b1;
      if (wd_expire) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        timeout     <= 1'b1;
        tx_ready    <= 1'b1;
        busy        <= 1'b0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: if (tx_valid && tx_ready) begin
            frame       <= {1'b1, ~^tx_data, tx_data};
            inh_cnt     <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= (INHIBIT_CYCLES == 1);
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= INHIBIT;
          end
          INHIBIT: begin
            inh_cnt <= inh_cnt + 1'b1;
            if (inh_cnt == INH_LAST) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b1;
              nfall       <= '0;
              wd_cnt      <= '0;
              state       <= REQ;
            end else if (inh_cnt == INH_LAST - 1'b1) begin
              ps2_data_oe <= 1'b1;
            end
          end
          REQ, SHIFT: if (fall) begin
            nfall <= nfall + 1'b1;
            if (nfall == 4'd10) begin
              ack_ok      <= ~data_s;
              ps2_data_oe <= 1'b0;
              state       <= WAIT_IDLE;
            end else begin
              // Open-drain: drive low for a 0, release for a 1 (stop bit releases).
              ps2_data_oe <= ~frame[0];
              frame       <= {1'b0, frame[9:1]};
              state       <= SHIFT;
            end
          end
          WAIT_IDLE: if (clk_s && data_s) begin
            done     <= ack_ok;
            ack_err  <= ~ack_ok;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural device, a frame model and
// a per-cycle monitor that checks inhibit timing, handshake and result pulses.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TO  = 5000;
  localparam logic [2:0] K_DONE = 3'b001, K_NACK = 3'b010, K_TO = 3'b100;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic done, ack_err, timeout;
  logic dev_clk = 1'b1, dev_data = 1'b1;

  int checks = 0, failures = 0;
  int k = -1, acc_cnt = 0;
  logic [7:0] acc_data = '0;
  logic exp_pend = 1'b0;
  logic [2:0] exp_kind = K_DONE;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .done(done), .ack_err(ack_err), .timeout(timeout));

  // Wired-AND open-drain bus: either side can pull low.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // Monitor: inhibit window timing, ready/busy relation and result pulse legality.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      k = -1;
    end else begin
      chk("busy_vs_ready", busy, !tx_ready);
      if (k >= 0) begin
        k++;
        chk("inhibit_clk_oe", ps2_clk_oe, k <= INH);
        chk("inhibit_data_oe", ps2_data_oe, k >= INH);
        if (k > INH) k = -1;
      end else begin
        chk("clk_oe_outside_inhibit", ps2_clk_oe, 0);
      end
      if (tx_valid && tx_ready) begin
        k = 0;
        acc_cnt++;
        acc_data = tx_data;
      end
      if (done || ack_err || timeout) begin
        chk("one_result_pulse", 32'(done) + 32'(ack_err) + 32'(timeout), 1);
        chk("result_expected", exp_pend, 1);
        chk("result_kind", {timeout, ack_err, done}, exp_kind);
        chk("ready_at_result", tx_ready, 1);
        chk("oe_at_result", {ps2_clk_oe, ps2_data_oe}, 0);
        exp_pend = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && n < INH + 50) begin tick(1); n++; end
    chk("request_seen", n < INH + 50, 1);
  endtask

  // Device: samples start before the first fall, then bits on rises 1..10, ACK after rise 10.
  task automatic dev_xfer(input int hp, input bit ack, input int stop_after, output logic [10:0] smp);
    int n;
    smp = '0;
    wait_req(n);
    tick(hp);
    smp[0] = ps2_data_i;
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      tick(hp);
      if (i == stop_after) return;
      dev_clk = 1'b1;
      if (i <= 10) smp[i] = ps2_data_i;
      if (i == 10 && ack) dev_data = 1'b0;
      tick(hp);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (exp_pend && n < 3000) begin tick(1); n++; end
    chk(name, exp_pend, 0);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input int hp, output logic [10:0] smp);
    exp_kind = ack ? K_DONE : K_NACK;
    exp_pend = 1'b1;
    send(b);
    dev_xfer(hp, ack, 99, smp);
    chk("frame_bits", smp, frame_of(b));
    wait_result("result_arrived");
  endtask

  initial begin
    logic [10:0] smp;
    int n, a0;
    logic [7:0] b;
    bit ack;

    tick(3);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("rst_pulses", {done, ack_err, timeout}, 0);
    rst_n = 1'b1;
    tick(3);

    run_frame(8'hED, 1, 40, smp);
    chk("ed_literal", smp, 11'h7DA);
    chk("ed_ready_after", tx_ready, 1);
    run_frame(8'hF4, 1, 30, smp);
    chk("f4_literal", smp, 11'h5E8);
    run_frame(8'h00, 0, 25, smp);
    chk("00_literal", smp, 11'h600);

    // Device never clocks: watchdog fires TO cycles into REQ.
    exp_kind = K_TO;
    exp_pend = 1'b1;
    send(8'h3A);
    wait_req(n);
    n = 0;
    while (!timeout && n < TO + 50) begin tick(1); n++; end
    chk("timeout_latency", n, TO);
    tick(2);
    chk("timeout_consumed", exp_pend, 0);
    chk("timeout_ready", tx_ready, 1);

    // Reset in the middle of the frame while the host is pulling data low.
    exp_kind = K_DONE;
    exp_pend = 1'b1;
    send(8'h55);
    dev_xfer(30, 1, 6, smp);
    tick(5);
    chk("pre_reset_data_oe", ps2_data_oe, 1);
    chk("pre_reset_busy", busy, 1);
    exp_pend = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_oe_drop", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("reset_no_pulse", {done, ack_err, timeout}, 0);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    run_frame(8'hFF, 1, 30, smp);
    chk("ff_literal", smp, 11'h7FE);

    // tx_valid held with a new byte while busy: second byte waits for IDLE.
    a0 = acc_cnt;
    exp_kind = K_DONE;
    exp_pend = 1'b1;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick(1);
    tx_data = 8'h3C;
    dev_xfer(30, 1, 99, smp);
    chk("hold_first_frame", smp, frame_of(8'hA5));
    wait_result("hold_first_result");
    chk("hold_accept_count", acc_cnt, a0 + 2);
    chk("hold_second_byte", acc_data, 8'h3C);
    exp_pend = 1'b1;
    tx_valid = 1'b0;
    dev_xfer(30, 1, 99, smp);
    chk("hold_second_frame", smp, frame_of(8'h3C));
    wait_result("hold_second_result");

    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      run_frame(b, ack, int'($urandom_range(20, 60)), smp);
      tick(int'($urandom_range(1, 20)));
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit actual=expired expected=finished");
    $fatal(1, "time limit");
  end
endmodule
